// File: rtl/goertzel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_pkg
// Description : Shared types and constants for the single-bin Goertzel stage.
//               fix_t is a signed 32.32 fixed-point word. The package also
//               holds the FSM state encoding and the default coefficient.
// Revision    : 1.0 - initial release
// ============================================================================
package goertzel_pkg;

    typedef logic signed [63:0] fix_t;

    localparam int FRAC_BITS = 32;

    // 2*cos(2*pi*k/N) default of 1.0 in 32.32
    localparam fix_t DEFAULT_COEF = 64'sh0000_0001_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_P4   = 3'd5,
        ST_OUT  = 3'd6
    } state_t;

endpackage : goertzel_pkg
`default_nettype wire

// File: rtl/fx_mul.sv
`default_nettype none
// ============================================================================
// Module      : fx_mul
// Description : Combinational signed 32.32 multiply. Forms the full 128-bit
//               signed product and keeps bits [95:32], which equals an
//               arithmetic right shift by FRAC_BITS truncated to 64 bits.
// Ports       : a, b  - signed 32.32 operands
//               p     - signed 32.32 product (wraps on overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module fx_mul
    import goertzel_pkg::*;
(
    input  fix_t a,
    input  fix_t b,
    output fix_t p
);

    logic signed [127:0] w_prod;
    // Integer overflow bits and sub-LSB fraction bits are deliberately dropped
    logic [63:0]         w_unused_bits;

    // Both operands signed and the target 128 bits wide: sign-extended multiply
    assign w_prod        = a * b;
    assign p             = w_prod[FRAC_BITS+63:FRAC_BITS];
    assign w_unused_bits = {w_prod[127:FRAC_BITS+64], w_prod[FRAC_BITS-1:0]};

endmodule : fx_mul
`default_nettype wire

// File: rtl/goertzel_core.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_core
// Description : Single-bin Goertzel filter. Runs the second-order recursion
//               over N_SAMPLES samples, then computes
//               |X|^2 = s1^2 + s2^2 - COEF*s1*s2 in four cycles that share
//               one multiplier, and presents it with a one-cycle done pulse.
// Ports       : clk      - system clock, rising edge
//               rstn     - asynchronous active-low reset
//               start    - begin (or restart) a block
//               valid_i  - data_i carries a new sample
//               data_i   - sample, signed 32.32
//               busy     - block in progress
//               done     - one-cycle pulse, power_o updated
//               power_o  - squared magnitude, signed 32.32, held
//               overrun  - one-cycle pulse, sample dropped in power phase
// Revision    : 1.0 - initial release
// ============================================================================
module goertzel_core
    import goertzel_pkg::*;
#(
    parameter int   N_SAMPLES = 205,
    parameter fix_t COEF      = DEFAULT_COEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        valid_i,
    input  logic [63:0] data_i,
    output logic        busy,
    output logic        done,
    output logic [63:0] power_o,
    output logic        overrun
);

    localparam int             CNT_W  = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_SAMPLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    fix_t             r_s1;
    fix_t             r_s2;
    fix_t             r_acc;
    fix_t             r_t;
    fix_t             r_power;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    fix_t             w_mul_a;
    fix_t             w_mul_b;
    fix_t             w_prod;
    fix_t             w_s0;
    logic             w_take;
    logic             w_last;
    logic             w_power_phase;

    // ------------------------------------------------------------------
    // Shared multiplier: operands selected by the current state
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_a = COEF;
        w_mul_b = r_s1;
        case (r_state)
            ST_P1: begin
                w_mul_a = r_s1;
                w_mul_b = r_s1;
            end
            ST_P2: begin
                w_mul_a = r_s2;
                w_mul_b = r_s2;
            end
            ST_P4: begin
                w_mul_a = r_t;
                w_mul_b = r_s2;
            end
            default: begin
                w_mul_a = COEF;
                w_mul_b = r_s1;
            end
        endcase
    end

    fx_mul u_fx_mul (
        .a (w_mul_a),
        .b (w_mul_b),
        .p (w_prod)
    );

    assign w_s0          = fix_t'(data_i) + w_prod - r_s2;
    // start has priority: a sample arriving with start is not accumulated
    assign w_take        = (r_state == ST_ACC) && valid_i && !start;
    assign w_last        = w_take && (r_cnt == C_LAST);
    assign w_power_phase = (r_state == ST_P1) || (r_state == ST_P2) ||
                           (r_state == ST_P3) || (r_state == ST_P4) ||
                           (r_state == ST_OUT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_ACC:  w_state_nxt = w_last ? ST_P1 : ST_ACC;
                ST_P1:   w_state_nxt = ST_P2;
                ST_P2:   w_state_nxt = ST_P3;
                ST_P3:   w_state_nxt = ST_P4;
                ST_P4:   w_state_nxt = ST_OUT;
                ST_OUT:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_acc     <= '0;
            r_t       <= '0;
            r_power   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= valid_i && w_power_phase && !start;
            if (start) begin
                // Restart from any state; a pending result is discarded
                r_s1   <= '0;
                r_s2   <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else begin
                case (r_state)
                    ST_ACC: begin
                        if (w_take) begin
                            r_s1  <= w_s0;
                            r_s2  <= r_s1;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_P1:   r_acc <= w_prod;
                    ST_P2:   r_acc <= r_acc + w_prod;
                    ST_P3:   r_t   <= w_prod;
                    ST_P4:   r_acc <= r_acc - w_prod;
                    ST_OUT: begin
                        r_power <= r_acc;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign power_o = r_power;
    assign overrun = r_overrun;

endmodule : goertzel_core
`default_nettype wire

// File: tb/tb_goertzel_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_goertzel_core
// Description : Self-checking bench for goertzel_core with N_SAMPLES=4 and
//               COEF=1.0. Table of blocks with hand-computed power, plus
//               sequences for restart, overrun and mid-block reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_goertzel_core;

    localparam int          N     = 4;
    localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] MONE  = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
    localparam logic [63:0] HALF  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] FIVE  = 64'h0000_0005_0000_0000;
    localparam logic [63:0] ZERO  = 64'h0;
    localparam logic [63:0] P3    = 64'h0000_0003_0000_0000;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        valid_i;
    logic [63:0] data_i;
    logic        busy;
    logic        done;
    logic [63:0] power_o;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;

    typedef struct packed {
        logic [3:0][63:0] x;       // x[0] is the first sample
        logic [3:0][3:0]  gap;     // idle cycles before each sample
        logic [63:0]      exp_pow;
    } vec_t;

    vec_t vecs [8];

    goertzel_core #(
        .N_SAMPLES (N),
        .COEF      (64'sh0000_0001_0000_0000)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .valid_i (valid_i),
        .data_i  (data_i),
        .busy    (busy),
        .done    (done),
        .power_o (power_o),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] x, input int gap);
        valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        valid_i = 1'b1;
        data_i  = x;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = ZERO;
    endtask

    // Called right after the negedge following the last accepted sample
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin : main
        int           lat;
        int           d0;
        int           o0;
        logic [63:0]  held;

        vecs[0] = '{x: {ONE, ONE, ONE, ONE},     gap: 16'h0000, exp_pow: P3};
        vecs[1] = '{x: {ZERO, ZERO, ZERO, ONE},  gap: 16'h0000, exp_pow: ONE};
        vecs[2] = '{x: {ZERO, ZERO, ZERO, ZERO}, gap: 16'h1302, exp_pow: ZERO};
        vecs[3] = '{x: {TWO, TWO, TWO, TWO},     gap: 16'h0000, exp_pow: 64'h0000_000C_0000_0000};
        vecs[4] = '{x: {MONE, ONE, MONE, ONE},   gap: 16'h0000, exp_pow: ONE};
        vecs[5] = '{x: {HALF, HALF, HALF, HALF}, gap: 16'h0000, exp_pow: 64'h0000_0000_C000_0000};
        vecs[6] = '{x: {ONE, ZERO, ZERO, ZERO},  gap: 16'h0000, exp_pow: ONE};
        vecs[7] = '{x: {MONE, MONE, MONE, MONE}, gap: 16'h0101, exp_pow: P3};

        rstn    = 1'b0;
        start   = 1'b0;
        valid_i = 1'b0;
        data_i  = ZERO;
        repeat (3) @(negedge clk);
        chk("reset busy",    64'(busy),    64'd0);
        chk("reset done",    64'(done),    64'd0);
        chk("reset overrun", 64'(overrun), 64'd0);
        chk("reset power",   power_o,      ZERO);
        rstn = 1'b1;
        @(negedge clk);

        // valid in IDLE is ignored without overrun
        o0 = ovr_cnt;
        send(FIVE, 0);
        send(FIVE, 0);
        #1;
        chk("idle valid overrun", 64'(ovr_cnt - o0), 64'd0);
        chk("idle busy", 64'(busy), 64'd0);

        // ---------------- table-driven blocks ----------------
        o0 = ovr_cnt;
        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt;
            start_pulse();
            chk($sformatf("v%0d busy after start", v), 64'(busy), 64'd1);
            for (int i = 0; i < N; i++) send(vecs[v].x[i], int'(vecs[v].gap[i]));
            wait_done(lat);
            chk($sformatf("v%0d done latency", v), 64'(lat), 64'd5);
            chk($sformatf("v%0d power", v), power_o, vecs[v].exp_pow);
            chk($sformatf("v%0d busy at done", v), 64'(busy), 64'd0);
            held = power_o;
            @(negedge clk);
            #1;
            chk($sformatf("v%0d done pulse width", v), 64'(done), 64'd0);
            chk($sformatf("v%0d power held", v), power_o, held);
            chk($sformatf("v%0d done count", v), 64'(done_cnt - d0), 64'd1);
            @(negedge clk);
        end
        chk("table no overrun", 64'(ovr_cnt - o0), 64'd0);

        // ---------------- restart mid-block ----------------
        d0 = done_cnt;
        start_pulse();
        send(FIVE, 0);
        send(FIVE, 0);
        start_pulse();
        for (int i = 0; i < N; i++) send(ONE, 0);
        wait_done(lat);
        chk("restart latency", 64'(lat), 64'd5);
        chk("restart power", power_o, P3);
        @(negedge clk);
        #1;
        chk("restart single done", 64'(done_cnt - d0), 64'd1);

        // ---------------- start together with valid ----------------
        start   = 1'b1;
        valid_i = 1'b1;
        data_i  = FIVE;
        @(negedge clk);
        start   = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < N; i++) send(ONE, 0);
        wait_done(lat);
        chk("start+valid latency", 64'(lat), 64'd5);
        chk("start+valid power", power_o, P3);
        @(negedge clk);

        // ---------------- overrun: valid held through P1..OUT ----------------
        d0 = done_cnt;
        o0 = ovr_cnt;
        start_pulse();
        valid_i = 1'b1;
        data_i  = ONE;
        repeat (N) @(negedge clk);
        data_i = FIVE;
        repeat (8) @(negedge clk);
        valid_i = 1'b0;
        data_i  = ZERO;
        @(negedge clk);
        #1;
        chk("overrun pulses", 64'(ovr_cnt - o0), 64'd5);
        chk("overrun done count", 64'(done_cnt - d0), 64'd1);
        chk("overrun power", power_o, P3);

        // ---------------- reset during ACC ----------------
        d0 = done_cnt;
        start_pulse();
        send(ONE, 0);
        send(ONE, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid reset busy",  64'(busy),    64'd0);
        chk("mid reset done",  64'(done),    64'd0);
        chk("mid reset power", power_o,      ZERO);
        chk("mid reset ovr",   64'(overrun), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("mid reset no done", 64'(done_cnt - d0), 64'd0);
        start_pulse();
        for (int i = 0; i < N; i++) send(ONE, 0);
        wait_done(lat);
        chk("post reset latency", 64'(lat), 64'd5);
        chk("post reset power", power_o, P3);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule : tb_goertzel_core
`default_nettype wire
